rename_recovery_ctrl: RTL and testbench

RENAME_RECOVERY_CTRL -- requirements
Module: rename_recovery_ctrl

---
 rtl/core_pkg.sv | 11 +
 rtl/rename_recovery_ctrl.sv | 91 +++++++++
 tb/tb_rename_recovery_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared rename widths, history-buffer entry and recovery FSM state
package core_pkg;
  localparam int ARCH_IDX_W = 5;
  localparam int PHYS_IDX_W = 6;
  typedef struct packed {
    logic [ARCH_IDX_W-1:0] arch_rd;
    logic [PHYS_IDX_W-1:0] old_phys;
    logic [PHYS_IDX_W-1:0] new_phys;
  } hb_entry_t;
  typedef enum logic [1:0] {IDLE, WALK, DONE} recov_state_t;
endpackage

// File: rtl/rename_recovery_ctrl.sv
// rename_recovery_ctrl: rename history buffer; records renames, frees retired old_phys, walks youngest-first on flush to restore the map (ports: rec_* in, ret_* in/out, flush_req in, walk_* out, busy/count/rec_ready out)
module rename_recovery_ctrl
  import core_pkg::*;
#(
  parameter int HB_DEPTH = 16,
  parameter int LANES = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [LANES-1:0]                      rec_en,
  input  logic [LANES-1:0][ARCH_IDX_W-1:0]      rec_arch_rd,
  input  logic [LANES-1:0][PHYS_IDX_W-1:0]      rec_old_phys,
  input  logic [LANES-1:0][PHYS_IDX_W-1:0]      rec_new_phys,
  output logic                                  rec_ready,
  input  logic [LANES-1:0]                      ret_en,
  output logic [LANES-1:0][PHYS_IDX_W-1:0]      ret_free_phys,
  input  logic                                  flush_req,
  output logic [LANES-1:0]                      walk_en,
  output logic [LANES-1:0][ARCH_IDX_W-1:0]      walk_arch_rd,
  output logic [LANES-1:0][PHYS_IDX_W-1:0]      walk_restore_phys,
  output logic [LANES-1:0][PHYS_IDX_W-1:0]      walk_free_phys,
  output logic                                  busy,
  output logic [$clog2(HB_DEPTH):0]             count
);
  localparam int PW = $clog2(HB_DEPTH);
  localparam int CW = PW + 1;
  hb_entry_t mem [HB_DEPTH];
  recov_state_t state, state_n;
  logic [PW-1:0] head, tail, head_n, tail_n;
  logic [CW-1:0] count_n, n_ret, n_rec, n_walk, post;
  logic [CW-1:0] rec_off [LANES];
  logic idle;
  assign idle = state == IDLE;
  assign busy = !idle;
  assign rec_ready = count <= CW'(HB_DEPTH - LANES) && idle && !flush_req;
  assign post = count - n_ret;
  assign n_walk = count >= CW'(LANES) ? CW'(LANES) : count;
  // rec_off packs enabled lanes into consecutive slots, keeping lane order
  always_comb begin
    n_ret = '0;
    n_rec = '0;
    for (int i = 0; i < LANES; i++) begin
      rec_off[i] = n_rec;
      n_rec = n_rec + CW'(rec_en[i] & rec_ready);
      n_ret = n_ret + CW'(ret_en[i] & idle);
    end
  end
  // retirement is folded into post, so a same-cycle flush walks only what remains
  always_comb begin
    state_n = state;
    head_n = head + PW'(n_ret);
    tail_n = tail + PW'(n_rec);
    count_n = post + n_rec;
    if (state == IDLE)
      state_n = flush_req ? (post != '0 ? WALK : DONE) : IDLE;
    else if (state == WALK) begin
      tail_n = tail - PW'(n_walk);
      count_n = count - n_walk;
      state_n = count == n_walk ? DONE : WALK;
    end else
      state_n = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      head <= head_n;
      tail <= tail_n;
      count <= count_n;
    end
  always_ff @(posedge clk)
    for (int i = 0; i < LANES; i++)
      if (rec_en[i] && rec_ready)
        mem[tail + PW'(rec_off[i])] <= {rec_arch_rd[i], rec_old_phys[i], rec_new_phys[i]};
  // lane i walks tail-1-i, so the youngest entry is on lane0 and the older one lands last
  always_comb
    for (int i = 0; i < LANES; i++) begin
      ret_free_phys[i] = mem[head + PW'(i)].old_phys;
      walk_en[i] = state == WALK && count > CW'(i);
      walk_arch_rd[i] = mem[tail - PW'(i + 1)].arch_rd;
      walk_restore_phys[i] = mem[tail - PW'(i + 1)].old_phys;
      walk_free_phys[i] = mem[tail - PW'(i + 1)].new_phys;
    end
  a_ret_thermo: assert property (@(posedge clk) disable iff (reset) (ret_en & (ret_en + LANES'(1))) == '0);
  a_ret_busy: assert property (@(posedge clk) disable iff (reset) busy |-> ret_en == '0);
  a_ret_count: assert property (@(posedge clk) disable iff (reset) CW'($countones(ret_en)) <= count);
endmodule

// File: tb/tb_rename_recovery_ctrl.sv
// tb_rename_recovery_ctrl: queue-model random and directed checks of rename_recovery_ctrl
module tb_rename_recovery_ctrl;
  typedef struct {
    logic [4:0] a;
    logic [5:0] o;
    logic [5:0] n;
  } ent_t;
  logic clk = 0;
  logic reset;
  logic [1:0] rec_en, ret_en, walk_en;
  logic [1:0][4:0] rec_arch_rd, walk_arch_rd;
  logic [1:0][5:0] rec_old_phys, rec_new_phys, ret_free_phys, walk_restore_phys, walk_free_phys;
  logic flush_req, rec_ready, busy;
  logic [4:0] count;
  ent_t q[$];
  int mode;
  int n_cmp = 0;
  int n_bad = 0;
  int busy_cycles;
  logic [5:0] rt [32];
  rename_recovery_ctrl dut (
    .clk(clk), .reset(reset), .rec_en(rec_en), .rec_arch_rd(rec_arch_rd),
    .rec_old_phys(rec_old_phys), .rec_new_phys(rec_new_phys), .rec_ready(rec_ready),
    .ret_en(ret_en), .ret_free_phys(ret_free_phys), .flush_req(flush_req),
    .walk_en(walk_en), .walk_arch_rd(walk_arch_rd), .walk_restore_phys(walk_restore_phys),
    .walk_free_phys(walk_free_phys), .busy(busy), .count(count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic rand_payload();
    for (int i = 0; i < 2; i++) begin
      rec_arch_rd[i] = 5'($urandom);
      rec_old_phys[i] = 6'($urandom);
      rec_new_phys[i] = 6'($urandom);
    end
  endtask
  task automatic do_reset();
    reset = 1;
    rec_en = '0;
    ret_en = '0;
    flush_req = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    q.delete();
    mode = 0;
  endtask
  // mode: 0 idle, 1 walking back the queue tail, 2 one-cycle recovery tail
  task automatic cycle(input logic [1:0] re, input logic [1:0] rte, input logic fl);
    logic [1:0] we;
    logic rdy;
    int k;
    rec_en = re;
    ret_en = rte;
    flush_req = fl;
    #1;
    rdy = mode == 0 && q.size() <= 14 && !fl;
    we = mode == 1 ? {q.size() >= 2, 1'b1} : 2'b00;
    check("count", count, q.size());
    check("busy", busy, mode != 0);
    check("rec_ready", rec_ready, rdy);
    check("walk_en", walk_en, we);
    for (int i = 0; i < 2; i++) begin
      if (mode == 0 && i < q.size()) check("ret_free_phys", ret_free_phys[i], q[i].o);
      if (we[i]) begin
        check("walk_arch_rd", walk_arch_rd[i], q[q.size() - 1 - i].a);
        check("walk_restore", walk_restore_phys[i], q[q.size() - 1 - i].o);
        check("walk_free", walk_free_phys[i], q[q.size() - 1 - i].n);
      end
    end
    if (busy) busy_cycles++;
    for (int i = 0; i < 2; i++)
      if (walk_en[i]) rt[walk_arch_rd[i]] = walk_restore_phys[i];
    @(posedge clk);
    if (mode == 0) begin
      k = int'(rte[0]) + int'(rte[1]);
      repeat (k) void'(q.pop_front());
      if (fl) mode = q.size() > 0 ? 1 : 2;
      else if (rdy)
        for (int i = 0; i < 2; i++)
          if (re[i]) q.push_back('{rec_arch_rd[i], rec_old_phys[i], rec_new_phys[i]});
    end else if (mode == 1) begin
      repeat (q.size() >= 2 ? 2 : 1) void'(q.pop_back());
      if (q.size() == 0) mode = 2;
    end else mode = 0;
    @(negedge clk);
    rec_en = '0;
    ret_en = '0;
    flush_req = 0;
  endtask
  initial begin
    int k;
    logic [1:0] rte;
    rand_payload();
    do_reset();
    cycle(2'b00, 2'b00, 0);
    // five singles then flush: 11,11,01 walk then DONE
    for (int i = 0; i < 5; i++) begin rand_payload(); cycle(2'b01, 2'b00, 0); end
    busy_cycles = 0;
    cycle(2'b00, 2'b00, 1);
    repeat (5) cycle(2'b00, 2'b00, 0);
    check("busy_len_walk", busy_cycles, 4);
    // fill to 15, then retire 2
    for (int i = 0; i < 15; i++) begin rand_payload(); cycle(2'b01, 2'b00, 0); end
    check("full_ready", rec_ready, 0);
    cycle(2'b00, 2'b11, 0);
    check("after_ret_count", count, 13);
    check("after_ret_ready", rec_ready, 1);
    // same arch twice: older lane must win in the rename table
    do_reset();
    rec_arch_rd[0] = 3; rec_old_phys[0] = 10; rec_new_phys[0] = 20;
    cycle(2'b01, 2'b00, 0);
    rec_arch_rd[0] = 3; rec_old_phys[0] = 20; rec_new_phys[0] = 21;
    cycle(2'b01, 2'b00, 0);
    rt[3] = 63;
    busy_cycles = 0;
    cycle(2'b00, 2'b00, 1);
    check("dup_free0", walk_free_phys[0], 21);
    check("dup_free1", walk_free_phys[1], 20);
    repeat (3) cycle(2'b00, 2'b00, 0);
    check("dup_rt3", rt[3], 10);
    check("dup_busy_len", busy_cycles, 2);
    // wrap: 20 pairs, then 3 entries straddling index 15->0
    do_reset();
    for (int i = 0; i < 20; i++) begin
      rand_payload(); cycle(2'b11, 2'b00, 0);
      cycle(2'b00, 2'b11, 0);
    end
    for (int i = 0; i < 7; i++) begin rand_payload(); cycle(2'b01, 2'b00, 0); end
    for (int i = 0; i < 7; i++) cycle(2'b00, 2'b01, 0);
    rand_payload(); cycle(2'b11, 2'b00, 0);
    rand_payload(); cycle(2'b10, 2'b00, 0);
    cycle(2'b00, 2'b00, 1);
    repeat (4) cycle(2'b00, 2'b00, 0);
    // retire the only entry with flush: straight to DONE
    rand_payload(); cycle(2'b01, 2'b00, 0);
    busy_cycles = 0;
    cycle(2'b00, 2'b01, 1);
    repeat (3) cycle(2'b00, 2'b00, 0);
    check("ret_flush_busy_len", busy_cycles, 1);
    // reset during the second walk cycle
    for (int i = 0; i < 3; i++) begin rand_payload(); cycle(2'b11, 2'b00, 0); end
    cycle(2'b00, 2'b00, 1);
    cycle(2'b00, 2'b00, 0);
    reset = 1;
    #1;
    check("rst_walk_en", walk_en, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    reset = 0;
    q.delete();
    mode = 0;
    repeat (3) cycle(2'b00, 2'b00, 0);
    // random traffic
    for (int n = 0; n < 600; n++) begin
      rand_payload();
      rte = 2'b00;
      if (mode == 0) begin
        k = $urandom_range(0, q.size() < 2 ? q.size() : 2);
        rte = k == 2 ? 2'b11 : k == 1 ? 2'b01 : 2'b00;
      end
      cycle(2'($urandom), rte, $urandom_range(0, 11) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
